pe_acc_seq_ctrl: RTL and testbench
==================================

Name: pe_acc_seq_ctrl

Overview:
- Job sequencer for the 16-input PE add tree and its downstream accumulator.
- Accepts one dot-product job at a time: mode plus beat count.
- Gates 16-operand beats into the tree with a valid/ready handshake and drives the tree mode select.
- Tracks beats through the tree pipeline, issues accumulator clear/enable strobes, and presents a result-valid handshake when the final sum is settled.

Parameters:
- PIPE_LAT, 2, cycles from operand-beat handshake to that beat's sum reaching the accumulator input (min 1).
- KLEN_W, 8, width of beat-count field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  job accept; high only in IDLE.
- cmd_mode  in  2  tree mode; bit1=1 selects mantissa (A*B) mode.
- cmd_klen  in  KLEN_W  beats minus one (0 => 1 beat, max 2^KLEN_W beats).
- op_valid  in  1  operand beat present at tree inputs.
- op_ready  out  1  beat accepted this cycle.
- flush  in  1  synchronous abort of the current job.
- tree_mode_sel  out  2  registered mode to the tree (mode_sel_pip1).
- acc_clr  out  1  accumulator loads (not adds) the tree result this cycle.
- acc_en  out  1  accumulator captures the tree result this cycle.
- res_valid  out  1  accumulator holds the final job result.
- res_ready  in  1  result consumer accept.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pipe tracker cleared, beat counter=0, tree_mode_sel=0, acc_clr=acc_en=res_valid=op_ready=busy=0, cmd_ready=1.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch mode into tree_mode_sel and latch klen; -> RUN. If mode[1]=1, effective klen=0 (single beat, no accumulation).
  - RUN: op_ready=1. Each op_valid&op_ready increments the beat counter and pushes {valid, first, last} into a PIPE_LAT-deep shift register. first marks beat 0; last marks beat index == klen. After the last handshake -> DRAIN, op_ready=0 from that cycle onward.
  - DRAIN: op_ready=0. Waits until the last-tagged entry exits the tracker; -> DONE on the cycle after it exits.
  - DONE: res_valid=1. Held until res_ready; on res_valid&res_ready -> IDLE, res_valid low next cycle.
- Tracker tail (cycle t+PIPE_LAT for a beat handshaken at t): acc_en=1. acc_clr=1 when the entry is first. A single-beat job has acc_clr=acc_en=1 in the same cycle.
- Latency: last beat handshake at t gives res_valid=1 at t+PIPE_LAT+1. One beat per cycle in RUN with op_valid held; no bubbles are inserted.
- tree_mode_sel is stable from the cycle after cmd accept until the next accept. It is not changed by flush or DONE.
- flush (any non-IDLE state): next cycle state=IDLE, tracker cleared, no further acc_en/acc_clr, res_valid=0. A result pending in DONE is discarded. Flush in IDLE has no effect. Flush and cmd_valid in the same cycle: flush wins, the cmd is not accepted, cmd_ready=0 that cycle only if not already IDLE.
- op_valid outside RUN is ignored (op_ready=0). Operands must be held by the source until handshaken.
- res_ready outside DONE is ignored.
- Max klen (all ones): the beat counter is KLEN_W+1 bits wide. No wrap before the last-beat compare.
- Async reset mid-job: immediate return to reset values; accumulator strobes stop the same instant.

Test Plan:
- PIPE_LAT=2, cmd mode=00 klen=3 at cycle 0, op_valid high from cycle 1 -> handshakes at cycles 1-4; acc_clr at 3 only; acc_en at 3-6; res_valid=1 at cycle 7; res_ready at 9 -> cmd_ready=1 at cycle 10.
- Mode=2'b10 with klen=5 -> exactly one beat accepted; acc_clr=acc_en=1 at handshake+2; res_valid at handshake+3; op_ready=0 after the first beat.
- klen=3 with op_valid toggling 1,0,1,0,... -> 4 handshakes over 7 cycles; acc_en pulses mirror handshakes shifted by 2; res_valid one cycle after the last acc_en.
- Flush asserted in RUN after beat 2 -> IDLE next cycle; in-flight beats produce no acc_en; res_valid stays 0; next cmd then accepted normally with acc_clr on its first beat.
- rst_n pulled low during DRAIN, released 3 cycles later -> all outputs at reset values throughout; cmd_ready=1; tree_mode_sel=0.
- klen=255 (KLEN_W=8) -> 256 handshakes; last flag on the 256th only; res_valid at last handshake+3; no counter wrap.

Source files
------------

// File: rtl/pe_acc_seq_ctrl.sv
// Job sequencer for the 16-input PE add tree: gates operand beats, tracks them
// through the tree pipeline, strobes the accumulator and hands off the result.
module pe_acc_seq_ctrl #(
    parameter int PIPE_LAT = 2,
    parameter int KLEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [KLEN_W-1:0] cmd_klen,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              flush,
    output logic [1:0]        tree_mode_sel,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    // state   | meaning
    // S_IDLE  | waiting for a job command
    // S_RUN   | accepting operand beats into the tree
    // S_DRAIN | all beats issued, waiting for the last one to leave the tree
    // S_DONE  | accumulator holds the final result, waiting for consumer
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_mode;
    logic [KLEN_W-1:0]   r_klen;
    logic [KLEN_W:0]     r_beat_cnt;
    logic [PIPE_LAT-1:0] r_pv;
    logic [PIPE_LAT-1:0] r_pf;
    logic [PIPE_LAT-1:0] r_pl;

    logic w_cmd_acc;
    logic w_op_hs;
    logic w_first;
    logic w_last;
    logic w_flush_act;
    logic w_tail_v;
    logic w_tail_f;
    logic w_tail_l;

    assign w_flush_act = flush && (r_state != S_IDLE);
    assign w_cmd_acc   = cmd_valid && (r_state == S_IDLE);
    assign w_op_hs     = op_valid && op_ready;
    // Counter is one bit wider than klen so the final compare never sees a wrap.
    assign w_first     = (r_beat_cnt == '0);
    assign w_last      = (r_beat_cnt == {1'b0, r_klen});
    assign w_tail_v    = r_pv[PIPE_LAT-1];
    assign w_tail_f    = r_pf[PIPE_LAT-1];
    assign w_tail_l    = r_pl[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (cmd_valid)            w_state_nxt = S_RUN;
            S_RUN:   if (w_op_hs && w_last)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_tail_v && w_tail_l) w_state_nxt = S_DONE;
            S_DONE:  if (res_ready)            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
        if (w_flush_act) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        op_ready  = (r_state == S_RUN);
        res_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        acc_en    = w_tail_v;
        acc_clr   = w_tail_v && w_tail_f;
    end

    // Mantissa mode forces a single-beat job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= '0;
            r_klen <= '0;
        end else if (w_cmd_acc) begin
            r_mode <= cmd_mode;
            r_klen <= cmd_mode[1] ? '0 : cmd_klen;
        end
    end

    assign tree_mode_sel = r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_cmd_acc) begin
            r_beat_cnt <= '0;
        end else if (w_op_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pf <= '0;
            r_pl <= '0;
        end else if (w_flush_act) begin
            r_pv <= '0;
            r_pf <= '0;
            r_pl <= '0;
        end else begin
            r_pv[0] <= w_op_hs;
            r_pf[0] <= w_op_hs && w_first;
            r_pl[0] <= w_op_hs && w_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pl[i] <= r_pl[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_seq_ctrl.sv
// Bench for pe_acc_seq_ctrl: a time-schedule model of jobs, beats and results
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_pe_acc_seq_ctrl;

    localparam int P  = 2;
    localparam int KW = 8;
    localparam int NL = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = 2'b00;
    logic [KW-1:0] cmd_klen = '0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic          flush = 1'b0;
    logic [1:0]    tree_mode_sel;
    logic          acc_clr;
    logic          acc_en;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          busy;

    pe_acc_seq_ctrl #(.PIPE_LAT(P), .KLEN_W(KW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_klen     (cmd_klen),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .flush        (flush),
        .tree_mode_sel(tree_mode_sel),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: job accepted / beats still owed / time of last beat / strobe schedule
    bit       m_act = 1'b0;
    int       m_left = 0;
    int       m_idx = 0;
    int       m_last = -100;
    bit [1:0] m_mode = 2'b00;
    bit       en_s[NL];
    bit       clr_s[NL];

    bit       l_en[NL];
    bit       l_clr[NL];
    bit       l_rv[NL];
    bit       l_cr[NL];
    bit       l_or[NL];
    bit       l_hs[NL];
    bit [1:0] l_mode[NL];

    always @(negedge clk) begin : cmp_blk
        int c;
        bit e_cr, e_or, e_rv, e_bz, e_en, e_clr;
        bit [1:0] e_mode;
        c = cyc;
        if (c < NL) begin
            l_en[c]   = acc_en;
            l_clr[c]  = acc_clr;
            l_rv[c]   = res_valid;
            l_cr[c]   = cmd_ready;
            l_or[c]   = op_ready;
            l_hs[c]   = op_ready && op_valid;
            l_mode[c] = tree_mode_sel;
        end
        if (!rst_n) begin
            m_act = 1'b0;
            m_mode = 2'b00;
            for (int k = 0; k < NL; k++) begin
                en_s[k] = 1'b0;
                clr_s[k] = 1'b0;
            end
        end
        e_cr   = !m_act;
        e_bz   = m_act;
        e_or   = m_act && (m_left > 0);
        e_rv   = m_act && (m_left == 0) && (c >= m_last + P + 1);
        e_en   = (c < NL) ? en_s[c] : 1'b0;
        e_clr  = (c < NL) ? clr_s[c] : 1'b0;
        e_mode = m_mode;
        check("cmd_ready", int'(cmd_ready), int'(e_cr));
        check("busy", int'(busy), int'(e_bz));
        check("op_ready", int'(op_ready), int'(e_or));
        check("res_valid", int'(res_valid), int'(e_rv));
        check("acc_en", int'(acc_en), int'(e_en));
        check("acc_clr", int'(acc_clr), int'(e_clr));
        check("tree_mode_sel", int'(tree_mode_sel), int'(e_mode));
        if (rst_n) begin
            if (m_act && flush) begin
                m_act = 1'b0;
                for (int k = c + 1; k < NL; k++) begin
                    en_s[k] = 1'b0;
                    clr_s[k] = 1'b0;
                end
            end else if (!m_act) begin
                if (cmd_valid) begin
                    m_act  = 1'b1;
                    m_mode = cmd_mode;
                    m_left = cmd_mode[1] ? 1 : int'(cmd_klen) + 1;
                    m_idx  = 0;
                    m_last = -100;
                end
            end else if (e_or && op_valid) begin
                if (c + P < NL) begin
                    en_s[c+P]  = 1'b1;
                    clr_s[c+P] = (m_idx == 0);
                end
                m_idx++;
                m_left--;
                if (m_left == 0) m_last = c;
            end else if (e_rv && res_ready) begin
                m_act = 1'b0;
            end
        end
    end

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int cnt(input int sel, input int a, input int b);
        int n;
        n = 0;
        for (int k = a; k <= b; k++) begin
            if (k >= 0 && k < NL) begin
                case (sel)
                    0: n += int'(l_en[k]);
                    1: n += int'(l_clr[k]);
                    2: n += int'(l_rv[k]);
                    default: n += int'(l_hs[k]);
                endcase
            end
        end
        return n;
    endfunction

    initial begin : stim
        int t;
        go(3);
        rst_n = 1'b1;
        go(5);

        // Basic 4-beat job
        t = cyc + 1;
        go(t);      cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_klen = 8'd3;
        go(t + 1);  cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 5);  op_valid = 1'b0;
        go(t + 9);  res_ready = 1'b1;
        go(t + 10); res_ready = 1'b0;
        go(t + 12);
        check("t1_clr_at3", int'(l_clr[t+3]), 1);
        check("t1_clr_count", cnt(1, t, t + 11), 1);
        check("t1_en_count", cnt(0, t, t + 11), 4);
        check("t1_en_at6", int'(l_en[t+6]), 1);
        check("t1_rv_at6", int'(l_rv[t+6]), 0);
        check("t1_rv_at7", int'(l_rv[t+7]), 1);
        check("t1_cr_at9", int'(l_cr[t+9]), 0);
        check("t1_cr_at10", int'(l_cr[t+10]), 1);

        // Mantissa mode: klen ignored, one beat
        t = cyc + 1;
        go(t);      cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_klen = 8'd5;
        go(t + 1);  cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 5);  op_valid = 1'b0;
        go(t + 6);  res_ready = 1'b1;
        go(t + 7);  res_ready = 1'b0;
        go(t + 9);
        check("t2_hs_count", cnt(3, t, t + 8), 1);
        check("t2_clr_at3", int'(l_clr[t+3]), 1);
        check("t2_en_at3", int'(l_en[t+3]), 1);
        check("t2_rv_at3", int'(l_rv[t+3]), 0);
        check("t2_rv_at4", int'(l_rv[t+4]), 1);
        check("t2_or_at2", int'(l_or[t+2]), 0);
        check("t2_mode_at2", int'(l_mode[t+2]), 2);

        // Toggling op_valid
        t = cyc + 1;
        go(t);      cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_klen = 8'd3;
        for (int k = 1; k <= 8; k++) begin
            go(t + k);
            cmd_valid = 1'b0;
            op_valid  = (k <= 7) && (k % 2 == 1);
        end
        go(t + 11); res_ready = 1'b1;
        go(t + 12); res_ready = 1'b0;
        go(t + 13);
        check("t3_hs_count", cnt(3, t, t + 12), 4);
        check("t3_en_count", cnt(0, t, t + 12), 4);
        check("t3_en_at8", int'(l_en[t+8]), 0);
        check("t3_en_at9", int'(l_en[t+9]), 1);
        check("t3_rv_at9", int'(l_rv[t+9]), 0);
        check("t3_rv_at10", int'(l_rv[t+10]), 1);

        // Flush after two beats, then a fresh job
        t = cyc + 1;
        go(t);      cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_klen = 8'd7;
        go(t + 1);  cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 3);  op_valid = 1'b0; flush = 1'b1;
        go(t + 4);  flush = 1'b0;
        go(t + 5);  cmd_valid = 1'b1; cmd_klen = 8'd1;
        go(t + 6);  cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 8);  op_valid = 1'b0;
        go(t + 10); res_ready = 1'b1;
        go(t + 11); res_ready = 1'b0;
        go(t + 12);
        check("t4_cr_at4", int'(l_cr[t+4]), 1);
        check("t4_en_at4", int'(l_en[t+4]), 0);
        check("t4_rv_none", cnt(2, t, t + 9), 0);
        check("t4_clr_at8", int'(l_clr[t+8]), 1);
        check("t4_rv_at10", int'(l_rv[t+10]), 1);

        // Async reset while draining
        t = cyc + 1;
        go(t);      cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_klen = 8'd1;
        go(t + 1);  cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 3);  op_valid = 1'b0; rst_n = 1'b0;
        go(t + 6);  rst_n = 1'b1;
        go(t + 8);
        check("t5_mode_at2", int'(l_mode[t+2]), 1);
        check("t5_en_at3", int'(l_en[t+3]), 0);
        check("t5_cr_at3", int'(l_cr[t+3]), 1);
        check("t5_cr_at5", int'(l_cr[t+5]), 1);
        check("t5_mode_at4", int'(l_mode[t+4]), 0);
        check("t5_en_count", cnt(0, t + 3, t + 7), 0);

        // Maximum beat count
        t = cyc + 1;
        go(t);       cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_klen = 8'd255;
        go(t + 1);   cmd_valid = 1'b0; op_valid = 1'b1;
        go(t + 261); op_valid = 1'b0;
        go(t + 262); res_ready = 1'b1;
        go(t + 263); res_ready = 1'b0;
        go(t + 265);
        check("t6_hs_count", cnt(3, t, t + 264), 256);
        check("t6_hs_at256", int'(l_hs[t+256]), 1);
        check("t6_or_at257", int'(l_or[t+257]), 0);
        check("t6_en_count", cnt(0, t, t + 264), 256);
        check("t6_clr_count", cnt(1, t, t + 264), 1);
        check("t6_rv_at258", int'(l_rv[t+258]), 0);
        check("t6_rv_at259", int'(l_rv[t+259]), 1);
        check("t6_cr_at263", int'(l_cr[t+263]), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
